// File: rtl/miniuart_ctrl_pkg.sv
// MiniUART register map, LSR bit positions, 115200-baud divisors and controller FSM states.
// The RDATA state exists only when MINIUART_CTRL_RX_EN is defined.
package miniuart_ctrl_pkg;

  localparam logic [2:0] OFF_UART_DATA = 3'd0;
  localparam logic [2:0] OFF_UART_LSR  = 3'd1;
  localparam logic [2:0] OFF_UART_DIVR = 3'd2;
  localparam logic [2:0] OFF_UART_DIVT = 3'd3;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;

  // 50 MHz system clock: transmit divides per bit, receive samples at 16x.
  localparam logic [31:0] BAUD_SND_115200 = 32'd434;
  localparam logic [31:0] BAUD_RCV_115200 = 32'd27;

`ifdef MINIUART_CTRL_RX_EN
  typedef enum logic [2:0] {
    ST_INIT_DIVT = 3'd0,
    ST_INIT_DIVR = 3'd1,
    ST_IDLE      = 3'd2,
    ST_POLL      = 3'd3,
    ST_CHECK     = 3'd4,
    ST_WDATA     = 3'd5,
    ST_RDATA     = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_INIT_DIVT = 3'd0,
    ST_INIT_DIVR = 3'd1,
    ST_IDLE      = 3'd2,
    ST_POLL      = 3'd3,
    ST_CHECK     = 3'd4,
    ST_WDATA     = 3'd5
  } state_t;
`endif

  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {24'b0, b};
  endfunction

endpackage

// File: rtl/miniuart_ctrl_fifo.sv
// Byte FIFO for the MiniUART controller: occupancy counter, wrapping pointers,
// sticky drop flag when a push meets a full FIFO.
module miniuart_ctrl_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_drop
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_drop;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // A push against a full FIFO is lost even if a pop frees a slot on the same edge.
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_push && w_full) r_drop <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_drop  = r_drop;

endmodule

// File: rtl/miniuart_ctrl.sv
// WISHBONE bus master for MiniUART: programs DIVT/DIVR, then drains the byte FIFO one byte per LSR poll.
// Define MINIUART_CTRL_RX_EN to add rx_data/rx_valid and the RDATA receive path.
module miniuart_ctrl
  import miniuart_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] DIV_TX     = BAUD_SND_115200,
  parameter logic [31:0] DIV_RX     = BAUD_RCV_115200,
  parameter int unsigned POLL_GAP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic        drop,
  output logic        init_done,
  output logic        busy,
  output logic [2:0]  m_off,
  output logic [31:0] m_din,
  input  logic [31:0] m_dout,
  output logic        m_stb,
  output logic        m_we,
  input  logic        m_ack
`ifdef MINIUART_CTRL_RX_EN
  ,
  output logic [7:0]  rx_data,
  output logic        rx_valid
`endif
);

  localparam int unsigned GAP_W = $clog2(POLL_GAP) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  state_t           r_state;
  logic             r_stb;
  logic             r_we;
  logic [2:0]       r_off;
  logic [31:0]      r_din;
  logic [7:0]       r_lsr;
  logic [GAP_W-1:0] r_gap;
  logic             r_init_done;
`ifdef MINIUART_CTRL_RX_EN
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
`endif

  logic       w_pop;
  logic [7:0] w_head;
  logic       w_empty;
  logic       w_poll_req;
  logic       w_unused;

  miniuart_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (wr_en),
    .i_data  (wr_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (full),
    .o_empty (w_empty),
    .o_drop  (drop)
  );

  assign w_pop = (r_state == ST_WDATA) && r_stb && m_ack;

`ifdef MINIUART_CTRL_RX_EN
  assign w_poll_req = 1'b1;
`else
  assign w_poll_req = !w_empty;
`endif

  // Each bus state raises m_stb on its first cycle, so m_stb is low for at least one cycle between accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT_DIVT;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_off       <= '0;
      r_din       <= '0;
      r_lsr       <= '0;
      r_gap       <= '0;
      r_init_done <= 1'b0;
`ifdef MINIUART_CTRL_RX_EN
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
`endif
    end else begin
`ifdef MINIUART_CTRL_RX_EN
      r_rx_valid <= 1'b0;
`endif
      case (r_state)
        ST_INIT_DIVT: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_off <= OFF_UART_DIVT;
            r_din <= DIV_TX;
          end else if (m_ack) begin
            r_stb   <= 1'b0;
            r_state <= ST_INIT_DIVR;
          end
        end
        ST_INIT_DIVR: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_off <= OFF_UART_DIVR;
            r_din <= DIV_RX;
          end else if (m_ack) begin
            r_stb       <= 1'b0;
            r_init_done <= 1'b1;
            r_gap       <= '0;
            r_state     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (r_gap != GAP_LAST) begin
            r_gap <= r_gap + 1'b1;
          end else if (w_poll_req) begin
            r_gap   <= '0;
            r_state <= ST_POLL;
          end
        end
        ST_POLL: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_we  <= 1'b0;
            r_off <= OFF_UART_LSR;
            r_din <= '0;
          end else if (m_ack) begin
            r_stb   <= 1'b0;
            r_lsr   <= m_dout[7:0];
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
`ifdef MINIUART_CTRL_RX_EN
          if (r_lsr[LSR_DR])
            r_state <= ST_RDATA;
          else
`endif
          if (r_lsr[LSR_THRE] && !w_empty)
            r_state <= ST_WDATA;
          else
            r_state <= ST_IDLE;
        end
        ST_WDATA: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_off <= OFF_UART_DATA;
            r_din <= byte_word(w_head);
          end else if (m_ack) begin
            r_stb   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
`ifdef MINIUART_CTRL_RX_EN
        ST_RDATA: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_we  <= 1'b0;
            r_off <= OFF_UART_DATA;
            r_din <= '0;
          end else if (m_ack) begin
            r_stb      <= 1'b0;
            r_rx_data  <= m_dout[7:0];
            r_rx_valid <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
`endif
        default: begin
          r_stb   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_unused  = ^{m_dout[31:8], r_lsr};

  assign empty     = w_empty;
  assign init_done = r_init_done;
  assign busy      = r_stb;
  assign m_stb     = r_stb;
  assign m_we      = r_we;
  assign m_off     = r_off;
  assign m_din     = r_din;
`ifdef MINIUART_CTRL_RX_EN
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
`endif

endmodule

// File: tb/tb_miniuart_ctrl.sv
// Directed bench for miniuart_ctrl with a one-cycle-ack MiniUART bus model and scripted LSR values.
// Define MINIUART_CTRL_RX_EN to exercise the receive path.
module tb_miniuart_ctrl;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam logic [2:0]  O_DATA = 3'd0;
  localparam logic [2:0]  O_LSR  = 3'd1;
  localparam logic [2:0]  O_DIVR = 3'd2;
  localparam logic [2:0]  O_DIVT = 3'd3;
  localparam logic [31:0] E_DIVT = 32'd434;
  localparam logic [31:0] E_DIVR = 32'd27;

  typedef struct {
    logic        we;
    logic [2:0]  off;
    logic [31:0] din;
    int          low;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        full, empty, drop, init_done, busy;
  logic [2:0]  m_off;
  logic [31:0] m_din;
  logic [31:0] m_dout;
  logic        m_stb, m_we;
  logic        m_ack = 1'b0;
`ifdef MINIUART_CTRL_RX_EN
  logic [7:0]  rx_data;
  logic        rx_valid;
  int          rx_cnt = 0;
  logic [7:0]  rx_last = 8'h00;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  txn_t log_q[$];
  int   low_run = 0;
  int   low_last = 0;

  logic [7:0] lsr_script [8];
  int         lsr_n = 0;
  int         lsr_base = 0;
  int         lsr_acks = 0;
  logic [7:0] lsr_dflt = 8'h00;
  logic [7:0] lsr_now;

  always #5 clk = ~clk;

  miniuart_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .DIV_TX     (E_DIVT),
    .DIV_RX     (E_DIVR),
    .POLL_GAP   (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .drop      (drop),
    .init_done (init_done),
    .busy      (busy),
    .m_off     (m_off),
    .m_din     (m_din),
    .m_dout    (m_dout),
    .m_stb     (m_stb),
    .m_we      (m_we),
    .m_ack     (m_ack)
`ifdef MINIUART_CTRL_RX_EN
    ,
    .rx_data   (rx_data),
    .rx_valid  (rx_valid)
`endif
  );

  always_comb begin
    lsr_now = lsr_dflt;
    if (lsr_acks - lsr_base < lsr_n) lsr_now = lsr_script[3'(lsr_acks - lsr_base)];
  end

  assign m_dout = (m_off == O_LSR) ? {24'h0, lsr_now} : {24'h0, 8'h55};

  // Bus model and transaction log
  always @(posedge clk) begin
    if (!m_stb) begin
      low_run = low_run + 1;
    end else if (low_run != 0) begin
      low_last = low_run;
      low_run  = 0;
    end
    if (m_stb && m_ack) log_q.push_back('{we: m_we, off: m_off, din: m_din, low: low_last});
    if (m_stb && m_ack && !m_we && m_off == O_LSR) lsr_acks <= lsr_acks + 1;
    m_ack <= m_stb && !m_ack;
`ifdef MINIUART_CTRL_RX_EN
    if (rx_valid) begin
      rx_cnt  = rx_cnt + 1;
      rx_last = rx_data;
    end
`endif
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int cnt(input int from, input logic we, input logic [2:0] off);
    int c = 0;
    for (int j = from; j < log_q.size(); j++)
      if (log_q[j].we == we && log_q[j].off == off) c++;
    return c;
  endfunction

  function automatic int find(input int from, input logic we, input logic [2:0] off, input int nth);
    int c = 0;
    for (int j = from; j < log_q.size(); j++) begin
      if (log_q[j].we == we && log_q[j].off == off) begin
        if (c == nth) return j;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic txn_t at(input int i);
    txn_t t;
    t = '{we: 1'b0, off: 3'b111, din: 32'hDEAD_DEAD, low: -1};
    if (i >= 0 && i < log_q.size()) t = log_q[i];
    return t;
  endfunction

  task automatic wait_cnt(input int from, input logic we, input logic [2:0] off, input int n,
                          input int budget, input string tag);
    int k = 0;
    while (cnt(from, we, off) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (cnt(from, we, off) < n) chk(tag, cnt(from, we, off), n);
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int   b, ir, iw, k, rx_c0;
    logic found;
    txn_t t;
    rx_c0 = 0;

    // 1: reset state and divisor programming
    @(negedge clk);
    @(negedge clk);
    chk("rst_stb", m_stb, 0);
    chk("rst_we", m_we, 0);
    chk("rst_off", m_off, 0);
    chk("rst_din", m_din, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_drop", drop, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    wait_cnt(0, 1'b1, O_DIVR, 1, 100, "t1_timeout");
    chk("t1_init_done", init_done, 1);
    t = at(0);
    chk("t1_divt_we", t.we, 1);
    chk("t1_divt_off", t.off, O_DIVT);
    chk("t1_divt_din", t.din, E_DIVT);
    t = at(1);
    chk("t1_divr_we", t.we, 1);
    chk("t1_divr_off", t.off, O_DIVR);
    chk("t1_divr_din", t.din, E_DIVR);
    repeat (30) @(negedge clk);
`ifndef MINIUART_CTRL_RX_EN
    chk("t1_quiet", log_q.size(), 2);
`endif

    // 2: one byte, THR ready on the first poll
    b = log_q.size();
    lsr_dflt = 8'h20;
    push(8'h37);
    wait_cnt(b, 1'b1, O_DATA, 1, 200, "t2_timeout");
    t = at(find(b, 1'b1, O_DATA, 0));
    chk("t2_din", t.din, 32'h0000_0037);
    chk("t2_empty", empty, 1);
`ifndef MINIUART_CTRL_RX_EN
    t = at(b);
    chk("t2_first_lsr", t.off, O_LSR);
    chk("t2_polls", cnt(b, 1'b0, O_LSR), 1);
`endif

    // 3: THR busy for three polls
    repeat (5) @(negedge clk);
    b = log_q.size();
    lsr_dflt = 8'h00;
    lsr_script[0] = 8'h00;
    lsr_script[1] = 8'h00;
    lsr_script[2] = 8'h00;
    lsr_script[3] = 8'h20;
    lsr_base = lsr_acks;
    lsr_n = 4;
    push(8'h41);
    wait_cnt(b, 1'b1, O_DATA, 1, 300, "t3_timeout");
    t = at(find(b, 1'b1, O_DATA, 0));
    chk("t3_din", t.din, 32'h0000_0041);
`ifndef MINIUART_CTRL_RX_EN
    chk("t3_polls", cnt(b, 1'b0, O_LSR), 4);
`endif
    for (int j = 0; j < 4; j++) begin
      t = at(find(b, 1'b0, O_LSR, j));
      chk($sformatf("t3_gap%0d", j), (t.low >= GAP), 1);
    end
    repeat (40) @(negedge clk);
    chk("t3_writes", cnt(b, 1'b1, O_DATA), 1);
    lsr_n = 0;

    // 4: fill, overflow, then drain in order
    b = log_q.size();
    lsr_dflt = 8'h00;
    for (int j = 1; j <= 8; j++) push(8'(j));
    chk("t4_full8", full, 1);
    chk("t4_nodrop8", drop, 0);
    push(8'h09);
    chk("t4_drop", drop, 1);
    chk("t4_full9", full, 1);
    lsr_dflt = 8'h20;
    wait_cnt(b, 1'b1, O_DATA, 8, 800, "t4_timeout");
    for (int j = 0; j < 8; j++) begin
      t = at(find(b, 1'b1, O_DATA, j));
      chk($sformatf("t4_din%0d", j), t.din, 32'(j + 1));
    end
    chk("t4_empty", empty, 1);
    chk("t4_drop_sticky", drop, 1);
    repeat (40) @(negedge clk);
    chk("t4_writes", cnt(b, 1'b1, O_DATA), 8);

    // 5: reset in the middle of a DATA write
    push(8'h5A);
    found = 1'b0;
    k = 0;
    while (!found && k < 200) begin
      @(negedge clk);
      if (m_stb && m_we && m_off == O_DATA) found = 1'b1;
      k++;
    end
    chk("t5_wdata_seen", found, 1);
    rst = 1'b1;
    #1;
    chk("t5_stb", m_stb, 0);
    chk("t5_busy", busy, 0);
    chk("t5_empty", empty, 1);
    chk("t5_init_done", init_done, 0);
    chk("t5_drop_clr", drop, 0);
    b = log_q.size();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_cnt(b, 1'b1, O_DIVR, 1, 100, "t5_timeout");
    t = at(b);
    chk("t5_divt_off", t.off, O_DIVT);
    chk("t5_divt_din", t.din, E_DIVT);
    t = at(b + 1);
    chk("t5_divr_off", t.off, O_DIVR);
    chk("t5_divr_din", t.din, E_DIVR);
    chk("t5_init_again", init_done, 1);
    repeat (30) @(negedge clk);
    chk("t5_byte_lost", cnt(b, 1'b1, O_DATA), 0);

    // 6: LSR reports both RX data and THR ready
    repeat (5) @(negedge clk);
    b = log_q.size();
`ifdef MINIUART_CTRL_RX_EN
    rx_c0 = rx_cnt;
`endif
    lsr_dflt = 8'h00;
    lsr_script[0] = 8'h21;
    lsr_script[1] = 8'h20;
    lsr_base = lsr_acks;
    lsr_n = 2;
    push(8'h37);
    wait_cnt(b, 1'b1, O_DATA, 1, 300, "t6_timeout");
    t = at(find(b, 1'b1, O_DATA, 0));
    chk("t6_din", t.din, 32'h0000_0037);
    ir = find(b, 1'b0, O_DATA, 0);
    iw = find(b, 1'b1, O_DATA, 0);
`ifdef MINIUART_CTRL_RX_EN
    chk("t6_read_first", (ir >= 0 && ir < iw), 1);
    repeat (5) @(negedge clk);
    chk("t6_rx_pulses", rx_cnt - rx_c0, 1);
    chk("t6_rx_data", rx_last, 8'h55);
    chk("t6_rx_valid_low", rx_valid, 0);
`else
    chk("t6_no_read", ir, -1);
    chk("t6_polls", cnt(b, 1'b0, O_LSR), 1);
    chk("t6_rx_unused", rx_c0 + iw - b, 1);
`endif
    lsr_n = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
